// File: rtl/hc595_display_monitor_pkg.sv
// Shared constants and types for the 74HC595 display-link monitor.
// Holds the display-code values, the digit count and the shift FSM states.
package hc595_display_monitor_pkg;

  localparam int SEG_W      = 5;
  localparam int NUM_DIGITS = 8;
  localparam int DIG_IDX_W  = $clog2(NUM_DIGITS);

  localparam logic [SEG_W-1:0] SEG_CODE_BLANK = 5'd16;
  localparam logic [SEG_W-1:0] SEG_CODE_MINUS = 5'd17;
  localparam logic [SEG_W-1:0] SEG_CODE_UNK   = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_FULL  = 2'd2
  } shift_state_t;

endpackage

// File: rtl/hc595_display_monitor_seg7_pattern_decode.sv
// Maps a lit-segment pattern {g,f,e,d,c,b,a} (1 = lit) back to a display code.
// Hex font with lower-case b/d; blank, minus and unknown get reserved codes.
module hc595_display_monitor_seg7_pattern_decode
  import hc595_display_monitor_pkg::*;
(
  input  logic [6:0]       pattern,
  output logic [SEG_W-1:0] code
);

  always_comb begin
    code = SEG_CODE_UNK;
    case (pattern)
      7'h3F: code = 5'd0;
      7'h06: code = 5'd1;
      7'h5B: code = 5'd2;
      7'h4F: code = 5'd3;
      7'h66: code = 5'd4;
      7'h6D: code = 5'd5;
      7'h7D: code = 5'd6;
      7'h07: code = 5'd7;
      7'h7F: code = 5'd8;
      7'h6F: code = 5'd9;
      7'h77: code = 5'd10;
      7'h7C: code = 5'd11;
      7'h39: code = 5'd12;
      7'h5E: code = 5'd13;
      7'h79: code = 5'd14;
      7'h71: code = 5'd15;
      7'h00: code = SEG_CODE_BLANK;
      7'h40: code = SEG_CODE_MINUS;
      default: code = SEG_CODE_UNK;
    endcase
  end

endmodule

// File: rtl/hc595_display_monitor.sv
// Snoops the 74HC595 display link, rebuilds each latched frame and keeps a
// per-digit decoded code/dot buffer that falls back to blank when not refreshed.
module hc595_display_monitor
  import hc595_display_monitor_pkg::*;
#(
  parameter int FRAME_BITS   = 16,
  parameter bit SEG_ACT_LOW  = 1'b1,
  parameter bit DIG_ACT_LOW  = 1'b1,
  parameter int STALE_CYCLES = 60000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sclk_in,
  input  logic                          sdio_in,
  input  logic                          rclk_in,
  output logic [NUM_DIGITS*SEG_W-1:0]   digit_code,
  output logic [NUM_DIGITS-1:0]         digit_dot,
  output logic [NUM_DIGITS-1:0]         digit_alive,
  output logic                          frame_upd,
  output logic                          frame_err
);

  localparam int CNT_W = $clog2(FRAME_BITS + 2);
  localparam int ST_W  = $clog2(STALE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(FRAME_BITS + 1);
  localparam logic [ST_W-1:0]  STALE_MAX = ST_W'(STALE_CYCLES);
  localparam logic [ST_W-1:0]  STALE_PRE = ST_W'(STALE_CYCLES - 1);

  logic [2:0]            sclk_sync;
  logic [2:0]            rclk_sync;
  logic [1:0]            sdio_sync;
  logic                  sclk_rise;
  logic                  rclk_rise;

  shift_state_t          state;
  logic [FRAME_BITS-1:0] shreg;
  logic [FRAME_BITS-1:0] shreg_nx;
  logic [CNT_W-1:0]      bit_cnt;
  logic [CNT_W-1:0]      cnt_nx;

  logic                  lat_vld;
  logic                  lat_ok;
  logic [FRAME_BITS-1:0] lat_frame;

  logic [NUM_DIGITS-1:0] dig_sel;
  logic [7:0]            seg_bits;
  logic                  sel_multi;
  logic                  wr_en;
  logic [DIG_IDX_W-1:0]  wr_idx;
  logic [SEG_W-1:0]      dec_code;

  logic [NUM_DIGITS-1:0][SEG_W-1:0] code_q;
  logic [ST_W-1:0]                  stale_cnt [NUM_DIGITS];

  // Two flops resolve metastability; the third gives the previous level for edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      rclk_sync <= '0;
      sdio_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[1:0], sclk_in};
      rclk_sync <= {rclk_sync[1:0], rclk_in};
      sdio_sync <= {sdio_sync[0], sdio_in};
    end
  end

  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  assign rclk_rise = rclk_sync[1] & ~rclk_sync[2];

  always_comb begin
    shreg_nx = shreg;
    cnt_nx   = bit_cnt;
    if (sclk_rise) begin
      shreg_nx = {shreg[FRAME_BITS-2:0], sdio_sync[1]};
      if (bit_cnt != CNT_SAT) cnt_nx = bit_cnt + 1'b1;
    end
  end

  // A latch in the same cycle as a shift sees the post-shift register and count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      shreg <= shreg_nx;
      if (rclk_rise) begin
        state   <= S_IDLE;
        bit_cnt <= '0;
      end else begin
        bit_cnt <= cnt_nx;
        case (state)
          S_IDLE:  if (sclk_rise) state <= (cnt_nx >= CNT_FULL) ? S_FULL : S_SHIFT;
          S_SHIFT: if (cnt_nx >= CNT_FULL) state <= S_FULL;
          S_FULL:  state <= S_FULL;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_vld   <= 1'b0;
      lat_ok    <= 1'b0;
      lat_frame <= '0;
    end else begin
      lat_vld <= rclk_rise;
      if (rclk_rise) begin
        lat_ok    <= (cnt_nx == CNT_FULL);
        lat_frame <= shreg_nx;
      end
    end
  end

  always_comb begin
    dig_sel   = DIG_ACT_LOW ? ~lat_frame[FRAME_BITS-1 -: NUM_DIGITS]
                            :  lat_frame[FRAME_BITS-1 -: NUM_DIGITS];
    seg_bits  = SEG_ACT_LOW ? ~lat_frame[7:0] : lat_frame[7:0];
    sel_multi = |(dig_sel & (dig_sel - 1'b1));
    wr_idx    = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (dig_sel[k]) wr_idx = DIG_IDX_W'(k);
    end
    wr_en = lat_vld & lat_ok & (dig_sel != '0) & ~sel_multi;
  end

  hc595_display_monitor_seg7_pattern_decode u_decode (
    .pattern (seg_bits[6:0]),
    .code    (dec_code)
  );

  // A digit with no write for STALE_CYCLES cycles is blanked until refreshed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_upd   <= 1'b0;
      frame_err   <= 1'b0;
      code_q      <= {NUM_DIGITS{SEG_CODE_BLANK}};
      digit_dot   <= '0;
      digit_alive <= '0;
      for (int k = 0; k < NUM_DIGITS; k++) stale_cnt[k] <= '0;
    end else begin
      frame_upd <= wr_en;
      frame_err <= lat_vld & (~lat_ok | sel_multi);
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (wr_en && (wr_idx == DIG_IDX_W'(k))) begin
          code_q[k]      <= dec_code;
          digit_dot[k]   <= seg_bits[7];
          digit_alive[k] <= 1'b1;
          stale_cnt[k]   <= '0;
        end else if (stale_cnt[k] != STALE_MAX) begin
          stale_cnt[k] <= stale_cnt[k] + 1'b1;
          if (stale_cnt[k] == STALE_PRE) begin
            digit_alive[k] <= 1'b0;
            code_q[k]      <= SEG_CODE_BLANK;
            digit_dot[k]   <= 1'b0;
          end
        end
      end
    end
  end

  assign digit_code = code_q;

endmodule
